// File: rtl/activation_pwq.sv
// rtl/activation_pwq.sv - pipelined piecewise-quadratic tanh/sigmoid/ReLU/identity activation unit
module activation_pwq #(
    parameter int WIDTH = 32,
    parameter int FL    = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              mode,
    input  logic signed [WIDTH-1:0] a,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] y
);
    localparam logic [1:0] MODE_TANH = 2'b00;
    localparam logic [1:0] MODE_SIG  = 2'b01;
    localparam logic [1:0] MODE_RELU = 2'b10;

    // Coefficients are authored with 24 fractional bits and rescaled to FL here.
    localparam int SH = 24 - FL;

    localparam logic signed [WIDTH-1:0] ONE     = WIDTH'(64'sd1 << FL);
    localparam logic signed [WIDTH-1:0] TWO     = WIDTH'(64'sd2 << FL);
    localparam logic signed [WIDTH-1:0] FOUR    = WIDTH'(64'sd4 << FL);
    localparam logic signed [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH+1:0] ONE_X   = (WIDTH+2)'(64'sd1 << FL);

    function automatic logic signed [WIDTH-1:0] scale(input logic signed [31:0] k);
        logic signed [31:0] s;
        s = k >>> SH;
        return WIDTH'(s);
    endfunction

    function automatic logic signed [WIDTH-1:0] coef_p1(input logic [1:0] seg);
        case (seg)
            2'd0:    coef_p1 = scale(-32'sd5536565);
            2'd1:    coef_p1 = scale(-32'sd2829259);
            2'd2:    coef_p1 = scale(-32'sd215503);
            default: coef_p1 = '0;
        endcase
    endfunction

    function automatic logic signed [WIDTH-1:0] coef_p2(input logic [1:0] seg);
        case (seg)
            2'd0:    coef_p2 = scale(32'sd18481378);
            2'd1:    coef_p2 = scale(32'sd11741166);
            2'd2:    coef_p2 = scale(32'sd1533840);
            default: coef_p2 = '0;
        endcase
    endfunction

    function automatic logic signed [WIDTH-1:0] coef_p3(input logic [1:0] seg);
        case (seg)
            2'd0:    coef_p3 = scale(-32'sd117373);
            2'd1:    coef_p3 = scale(32'sd3942042);
            2'd2:    coef_p3 = scale(32'sd14037513);
            default: coef_p3 = scale(32'sd16777216);
        endcase
    endfunction

    // Pipeline state
    logic                    v0_q, v1_q, v2_q;
    logic signed [WIDTH-1:0] abs0_q, sq0_q, a0_q;
    logic [1:0]              seg0_q, mode0_q;
    logic                    sign0_q;
    logic signed [WIDTH-1:0] t1_q, t2_q, a1_q;
    logic [1:0]              seg1_q, mode1_q;
    logic                    sign1_q;
    logic signed [WIDTH-1:0] y_q;

    logic adv;
    assign adv       = en & (~v2_q | out_ready);
    assign in_ready  = adv;
    assign out_valid = v2_q;
    assign y         = y_q;

    // Stage 0 datapath: argument prescale, saturating magnitude, square, segment pick
    logic signed [WIDTH-1:0]   x0_d, abs0_d, sq0_d;
    logic signed [2*WIDTH-1:0] sq0_full;
    logic [1:0]                seg0_d;
    always_comb begin
        x0_d = (mode == MODE_SIG) ? (a >>> 1) : a;
        if (x0_d == MIN_NEG) begin
            abs0_d = MAX_POS;
        end else if (x0_d[WIDTH-1]) begin
            abs0_d = -x0_d;
        end else begin
            abs0_d = x0_d;
        end
        sq0_full = (2*WIDTH)'(abs0_d) * (2*WIDTH)'(abs0_d);
        sq0_d    = sq0_full[FL+WIDTH-1:FL];
        if (abs0_d < ONE) begin
            seg0_d = 2'd0;
        end else if (abs0_d < TWO) begin
            seg0_d = 2'd1;
        end else if (abs0_d < FOUR) begin
            seg0_d = 2'd2;
        end else begin
            seg0_d = 2'd3;
        end
    end

    // Stage 1 datapath: quadratic and linear terms of the selected segment
    logic signed [WIDTH-1:0]   p1_c, p2_c, t1_d, t2_d;
    logic signed [2*WIDTH-1:0] m1_full, m2_full;
    always_comb begin
        p1_c    = coef_p1(seg0_q);
        p2_c    = coef_p2(seg0_q);
        m1_full = (2*WIDTH)'(p1_c) * (2*WIDTH)'(sq0_q);
        m2_full = (2*WIDTH)'(p2_c) * (2*WIDTH)'(abs0_q);
        t1_d    = m1_full[FL+WIDTH-1:FL];
        t2_d    = m2_full[FL+WIDTH-1:FL];
    end

    // Stage 2 datapath: polynomial sum, clamp to [0, ONE], sign restore, mode select
    logic signed [WIDTH+1:0] sum_c;
    logic signed [WIDTH-1:0] p3_c, yabs_c, t_c, y_d;
    logic signed [WIDTH:0]   sig_c;
    always_comb begin
        p3_c  = coef_p3(seg1_q);
        sum_c = (WIDTH+2)'(t1_q) + (WIDTH+2)'(t2_q) + (WIDTH+2)'(p3_c);
        if (sum_c[WIDTH+1]) begin
            yabs_c = '0;
        end else if (sum_c > ONE_X) begin
            yabs_c = ONE;
        end else begin
            yabs_c = sum_c[WIDTH-1:0];
        end
        t_c   = sign1_q ? -yabs_c : yabs_c;
        sig_c = (WIDTH+1)'(t_c) + (WIDTH+1)'(ONE);
        case (mode1_q)
            MODE_TANH: y_d = t_c;
            MODE_SIG:  y_d = sig_c[WIDTH:1];
            MODE_RELU: y_d = a1_q[WIDTH-1] ? '0 : a1_q;
            default:   y_d = a1_q;
        endcase
    end

    logic unused_bits;
    assign unused_bits = ^{sq0_full[2*WIDTH-1:FL+WIDTH], sq0_full[FL-1:0],
                           m1_full[2*WIDTH-1:FL+WIDTH], m1_full[FL-1:0],
                           m2_full[2*WIDTH-1:FL+WIDTH], m2_full[FL-1:0],
                           sig_c[0], sum_c[WIDTH]};

    // All stages advance together; a held output stalls the whole pipe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v0_q    <= 1'b0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            abs0_q  <= '0;
            sq0_q   <= '0;
            a0_q    <= '0;
            seg0_q  <= '0;
            mode0_q <= '0;
            sign0_q <= 1'b0;
            t1_q    <= '0;
            t2_q    <= '0;
            a1_q    <= '0;
            seg1_q  <= '0;
            mode1_q <= '0;
            sign1_q <= 1'b0;
            y_q     <= '0;
        end else if (adv) begin
            v0_q    <= in_valid;
            abs0_q  <= abs0_d;
            sq0_q   <= sq0_d;
            a0_q    <= a;
            seg0_q  <= seg0_d;
            mode0_q <= mode;
            sign0_q <= x0_d[WIDTH-1];

            v1_q    <= v0_q;
            t1_q    <= t1_d;
            t2_q    <= t2_d;
            a1_q    <= a0_q;
            seg1_q  <= seg0_q;
            mode1_q <= mode0_q;
            sign1_q <= sign0_q;

            v2_q    <= v1_q;
            if (v1_q) begin
                y_q <= y_d;
            end
        end
    end
endmodule

// File: tb/tb_activation_pwq.sv
// tb/tb_activation_pwq.sv - randomized and directed bench for activation_pwq
module tb_activation_pwq;
    localparam longint ONE = 64'sd16777216;

    logic clk = 1'b0;
    logic rst, en, in_valid, in_ready, out_valid, out_ready;
    logic [1:0] mode;
    logic signed [31:0] a, y;

    always #5 clk = ~clk;

    activation_pwq #(.WIDTH(32), .FL(24)) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .a(a), .out_valid(out_valid), .out_ready(out_ready), .y(y)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    longint P1[4] = '{-64'sd5536565, -64'sd2829259, -64'sd215503, 64'sd0};
    longint P2[4] = '{64'sd18481378, 64'sd11741166, 64'sd1533840, 64'sd0};
    longint P3[4] = '{-64'sd117373, 64'sd3942042, 64'sd14037513, 64'sd16777216};

    // Reference: evaluate the activation from the segment table with wide integers
    function automatic logic [31:0] model(input logic [1:0] m, input logic [31:0] av);
        longint sa, x, ax, sq, yabs, t, r;
        int s;
        logic neg;
        sa = longint'($signed(av));
        if (m == 2'b11) return av;
        if (m == 2'b10) return (sa < 0) ? 32'd0 : av;
        x   = (m == 2'b01) ? (sa >>> 1) : sa;
        neg = (x < 0);
        ax  = neg ? -x : x;
        if (ax > 64'sh7FFFFFFF) ax = 64'sh7FFFFFFF;
        if (ax >= 4 * ONE) begin
            yabs = ONE;
        end else begin
            s    = (ax < ONE) ? 0 : ((ax < 2 * ONE) ? 1 : 2);
            sq   = (ax * ax) >>> 24;
            yabs = ((P1[s] * sq) >>> 24) + ((P2[s] * ax) >>> 24) + P3[s];
            if (yabs < 0) yabs = 0;
            if (yabs > ONE) yabs = ONE;
        end
        t = neg ? -yabs : yabs;
        r = (m == 2'b00) ? t : ((t + ONE) >>> 1);
        return 32'(r);
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        case ($urandom_range(0, 3))
            0: v = $urandom;
            1: v = $urandom_range(0, 32'h06000000);
            2: v = 32'h0 - $urandom_range(0, 32'h06000000);
            default: begin
                v = $urandom_range(0, 8) << 24;
                if ($urandom_range(0, 1) == 1) v = 32'h0 - v;
            end
        endcase
        return v;
    endfunction

    task automatic cyc(input logic iv, input logic [1:0] m, input logic [31:0] av,
                       input logic ordy, input logic e,
                       output logic acc, output logic fire, output logic rdy,
                       output logic ov, output logic [31:0] yo);
        @(negedge clk);
        in_valid  = iv;
        mode      = m;
        a         = av;
        out_ready = ordy;
        en        = e;
        #1;
        rdy  = in_ready;
        ov   = out_valid;
        yo   = y;
        acc  = iv & in_ready;
        fire = out_valid & ordy & e;
        if (acc) exp_q.push_back(model(m, av));
    endtask

    task automatic run_one(input logic [1:0] m, input logic [31:0] av,
                           input int off_start, input int off_len,
                           output logic [31:0] yo, output int lat, output logic got);
        logic acc, fire, rdy, ov;
        logic [31:0] yv;
        int k;
        got = 1'b0; lat = 0; yo = '0; k = 0; acc = 1'b0;
        while (!acc && k < 20) begin
            cyc(1'b1, m, av, 1'b1, 1'b1, acc, fire, rdy, ov, yv);
            k++;
        end
        if (!acc) return;
        for (int i = 1; i <= 20 && !got; i++) begin
            cyc(1'b0, m, 32'd0, 1'b1, !(i >= off_start && i < off_start + off_len),
                acc, fire, rdy, ov, yv);
            if (fire) begin
                got = 1'b1; lat = i; yo = yv;
            end
        end
    endtask

    task automatic test_reset();
        logic acc, fire, rdy, ov;
        logic [31:0] yo;
        rst = 1'b1; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode = 2'b00; a = '0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_tests++;
        if (y !== 32'd0) begin n_fail++; $display("FAIL reset_y: got %h expected 00000000", y); end
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b0, 2'b00, 32'd0, 1'b1, 1'b1, acc, fire, rdy, ov, yo);
        n_tests++;
        if (rdy !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", rdy); end
    endtask

    logic [1:0]  dm [13] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01,
                             2'b10, 2'b10, 2'b11};
    logic [31:0] da [13] = '{32'h00000000, 32'h00800000, 32'h05000000, 32'hFB000000, 32'h80000000,
                             32'h00000000, 32'h0A000000, 32'hF6000000, 32'h01000000, 32'h02000000,
                             32'hFD000000, 32'h02800000, 32'hFD000000};
    logic [31:0] de [13] = '{32'h00000000, 32'h00764D7F, 32'h01000000, 32'hFF000000, 32'hFF000000,
                             32'h00800000, 32'h01000000, 32'h00000000, 32'h00BB0000, 32'h00E17C69,
                             32'h00000000, 32'h02800000, 32'hFD000000};
    int          dt [13] = '{0, 32'h10000, 0, 0, 0, 0, 0, 0, 32'h10000, 32'h10000, 0, 0, 0};

    task automatic test_directed();
        logic [31:0] yo, expv;
        int lat;
        logic got;
        longint d;
        for (int i = 0; i < 13; i++) begin
            run_one(dm[i], da[i], 0, 0, yo, lat, got);
            n_tests++;
            if (!got) begin
                n_fail++; $display("FAIL dir_timeout[%0d]: got no output expected one", i);
                exp_q.delete();
                continue;
            end
            expv = exp_q.pop_front();
            n_tests++;
            if (lat != 3) begin n_fail++; $display("FAIL dir_latency[%0d]: got %0d expected 3", i, lat); end
            n_tests++;
            if (yo !== expv) begin n_fail++; $display("FAIL dir_model[%0d]: got %h expected %h", i, yo, expv); end
            d = longint'($signed(yo)) - longint'($signed(de[i]));
            if (d < 0) d = -d;
            n_tests++;
            if (d > longint'(dt[i])) begin
                n_fail++; $display("FAIL dir_value[%0d]: got %h expected %h +/- %h", i, yo, de[i], dt[i]);
            end
        end
    endtask

    task automatic test_latency_en();
        logic [31:0] yo, expv;
        int lat;
        logic got, acc, fire, rdy, ov;
        cyc(1'b0, 2'b00, 32'd0, 1'b1, 1'b0, acc, fire, rdy, ov, yo);
        n_tests++;
        if (rdy !== 1'b0) begin n_fail++; $display("FAIL en_low_in_ready: got %b expected 0", rdy); end
        run_one(2'b01, 32'h01800000, 1, 2, yo, lat, got);
        n_tests++;
        if (!got || lat != 5) begin
            n_fail++; $display("FAIL en_stretch_latency: got %0d expected 5", lat);
        end
        if (got) begin
            expv = exp_q.pop_front();
            n_tests++;
            if (yo !== expv) begin n_fail++; $display("FAIL en_stretch_value: got %h expected %h", yo, expv); end
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [31:0] bp_a [8];
        logic [31:0] yo, yhold, expv;
        logic acc, fire, rdy, ov, ordy;
        int sent, got;
        for (int i = 0; i < 8; i++) bp_a[i] = rand_operand();
        sent = 0; got = 0; yhold = '0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            ordy = !(c >= 4 && c <= 6);
            cyc(sent < 8, 2'(sent % 4), bp_a[sent % 8], ordy, 1'b1, acc, fire, rdy, ov, yo);
            if (c == 3) begin
                n_tests++;
                if (!(acc && fire)) begin
                    n_fail++; $display("FAIL bp_simultaneous: got acc=%b fire=%b expected 1 1", acc, fire);
                end
            end
            if (c >= 4 && c <= 6) begin
                n_tests++;
                if (rdy !== 1'b0 || ov !== 1'b1) begin
                    n_fail++; $display("FAIL bp_stall: got in_ready=%b out_valid=%b expected 0 1", rdy, ov);
                end
                if (c == 4) yhold = yo;
                else begin
                    n_tests++;
                    if (yo !== yhold) begin n_fail++; $display("FAIL bp_hold: got %h expected %h", yo, yhold); end
                end
            end
            if (acc) sent++;
            if (fire) begin
                got++;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL bp_extra: got %h expected nothing", yo);
                end else begin
                    expv = exp_q.pop_front();
                    if (yo !== expv) begin n_fail++; $display("FAIL bp_value: got %h expected %h", yo, expv); end
                end
            end
        end
        n_tests++;
        if (got != 8 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL bp_count: got %0d outputs expected 8 (left %0d)", got, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_random();
        logic [31:0] yo, yprev, expv, av;
        logic acc, fire, rdy, ov, iv, ordy, e, hold_prev;
        logic [1:0] m;
        hold_prev = 1'b0; yprev = '0;
        for (int c = 0; c < 400; c++) begin
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 4) != 0);
            e    = ($urandom_range(0, 9) != 0);
            m    = 2'($urandom_range(0, 3));
            av   = rand_operand();
            cyc(iv, m, av, ordy, e, acc, fire, rdy, ov, yo);
            if (hold_prev) begin
                n_tests++;
                if (ov !== 1'b1 || yo !== yprev) begin
                    n_fail++; $display("FAIL rand_hold: got %b/%h expected 1/%h", ov, yo, yprev);
                end
            end
            hold_prev = ov & !fire;
            yprev     = yo;
            if (!e) begin
                n_tests++;
                if (rdy !== 1'b0) begin n_fail++; $display("FAIL rand_en_ready: got %b expected 0", rdy); end
            end
            if (fire) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rand_extra: got %h expected nothing", yo);
                end else begin
                    expv = exp_q.pop_front();
                    if (yo !== expv) begin n_fail++; $display("FAIL rand_value: got %h expected %h", yo, expv); end
                end
            end
        end
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            cyc(1'b0, 2'b00, 32'd0, 1'b1, 1'b1, acc, fire, rdy, ov, yo);
            if (fire) begin
                expv = exp_q.pop_front();
                n_tests++;
                if (yo !== expv) begin n_fail++; $display("FAIL rand_drain: got %h expected %h", yo, expv); end
            end
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL rand_lost: got %0d pending expected 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        logic [31:0] yo, expv;
        logic acc, fire, rdy, ov, got;
        int lat;
        for (int i = 0; i < 3; i++) cyc(1'b1, 2'(i), 32'h01000000, 1'b1, 1'b1, acc, fire, rdy, ov, yo);
        cyc(1'b0, 2'b00, 32'd0, 1'b0, 1'b1, acc, fire, rdy, ov, yo);
        n_tests++;
        if (ov !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid: got %b expected 1", ov); end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || y !== 32'd0) begin
            n_fail++; $display("FAIL rst_async: got %b/%h expected 0/00000000", out_valid, y);
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        cyc(1'b0, 2'b00, 32'd0, 1'b1, 1'b1, acc, fire, rdy, ov, yo);
        n_tests++;
        if (rdy !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b expected 1", rdy); end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 2'b00, 32'd0, 1'b1, 1'b1, acc, fire, rdy, ov, yo);
            n_tests++;
            if (ov !== 1'b0) begin n_fail++; $display("FAIL rst_stale: got %b expected 0", ov); end
        end
        run_one(2'b00, 32'hFF800000, 0, 0, yo, lat, got);
        n_tests++;
        if (!got || lat != 3) begin n_fail++; $display("FAIL rst_next_latency: got %0d expected 3", lat); end
        if (got) begin
            expv = exp_q.pop_front();
            n_tests++;
            if (yo !== expv) begin n_fail++; $display("FAIL rst_next_value: got %h expected %h", yo, expv); end
        end
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish within 500000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_latency_en();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
